// File: rtl/mant_normalize_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mant_normalize_pkg
// Purpose  : Shared constants for the mantissa normalizer: the mantissa and
//            shift-count widths, the FSM state encoding, and the stop test.
// Revision : 1.0 - initial release
// ============================================================================
package mant_normalize_pkg;

    localparam int MANT_W  = 27;    // hidden bit at [26], G/R/S at [2:0]
    localparam int SHIFT_W = 5;     // holds 0..26

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Normalization stops when the hidden bit is set, when there is nothing
    // to normalize, or when the exponent has reached its floor (denormal).
    function automatic logic stop_cond(input logic [MANT_W-1:0] mant,
                                       input logic              exp_is_zero);
        return mant[MANT_W-1] | ~(|mant) | exp_is_zero;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mant_normalize_if.sv
`default_nettype none
// ============================================================================
// Module   : mant_normalize_if
// Purpose  : Valid/ready bundle between an upstream producer, the mantissa
//            normalizer and the downstream packer.
//   in_valid/in_ready/in_mant/in_exp           : input word handshake
//   out_valid/out_ready/out_mant/out_exp/
//   out_shift/out_zero                         : result handshake
//   modport master : upstream/downstream side (drives inputs, out_ready)
//   modport slave  : normalizer side
// Revision : 1.0 - initial release
// ============================================================================
interface mant_normalize_if #(
    parameter int W = 8
);
    import mant_normalize_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [MANT_W-1:0]   in_mant;
    logic [W+1:0]        in_exp;
    logic                out_valid;
    logic                out_ready;
    logic [MANT_W-1:0]   out_mant;
    logic [W+1:0]        out_exp;
    logic [SHIFT_W-1:0]  out_shift;
    logic                out_zero;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_shift, out_zero
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_shift, out_zero
    );

endinterface
`default_nettype wire

// File: rtl/mant_normalize.sv
`default_nettype none
// ============================================================================
// Module   : mant_normalize
// Purpose  : Iterative left-normalizer for a 27-bit mantissa. One word at a
//            time: accept in IDLE, shift one bit per cycle in SHIFT until the
//            hidden bit is set / mantissa is zero / exponent hits 0, then hold
//            the result in DONE until the downstream takes it.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous, active-low
//            bus   - mant_normalize_if.slave (input word + result handshake)
// Revision : 1.0 - initial release
// ============================================================================
module mant_normalize
    import mant_normalize_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mant_normalize_if.slave  bus
);

    localparam logic [W+1:0]       c_exp_one   = {{(W+1){1'b0}}, 1'b1};
    localparam logic [SHIFT_W-1:0] c_shift_one = {{(SHIFT_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [MANT_W-1:0]  r_mant;
    logic [W+1:0]       r_exp;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_zero;
    // Registered stop test. It is computed one step ahead so the 27-bit zero
    // detect never sits in series with the shifter; r_stop_vld marks that the
    // first evaluation (on the freshly captured word) has been done.
    logic               r_stop;
    logic               r_stop_vld;

    logic [MANT_W-1:0]  w_mant_shl;
    logic [W+1:0]       w_exp_dec;
    logic               w_stop_now;
    logic               w_stop_nxt;

    assign w_mant_shl = {r_mant[MANT_W-2:0], 1'b0};
    // Only used when r_exp != 0 (exp == 0 is a stop condition), so no wrap.
    assign w_exp_dec  = r_exp - c_exp_one;
    assign w_stop_now = stop_cond(r_mant, r_exp == '0);
    assign w_stop_nxt = stop_cond(w_mant_shl, w_exp_dec == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_mant     <= '0;
            r_exp      <= '0;
            r_shift    <= '0;
            r_zero     <= 1'b0;
            r_stop     <= 1'b0;
            r_stop_vld <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_mant     <= bus.in_mant;
                        r_exp      <= bus.in_exp;
                        r_shift    <= '0;
                        r_zero     <= (bus.in_mant == '0);
                        r_stop     <= 1'b0;
                        r_stop_vld <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!r_stop_vld) begin
                        r_stop     <= w_stop_now;
                        r_stop_vld <= 1'b1;
                    end else if (r_stop) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_mant  <= w_mant_shl;
                        r_exp   <= w_exp_dec;
                        r_shift <= r_shift + c_shift_one;
                        r_stop  <= w_stop_nxt;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_mant  = r_mant;
    assign bus.out_exp   = r_exp;
    assign bus.out_shift = r_shift;
    assign bus.out_zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mant_normalize.sv
`default_nettype none
// ============================================================================
// Module   : tb_mant_normalize
// Purpose  : Self-checking bench for mant_normalize. Expected results come
//            from a behavioural normalizer and flow through a scoreboard
//            queue from the point a word is driven to the point it emerges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mant_normalize;
    import mant_normalize_pkg::*;

    localparam int W  = 8;
    localparam int EW = W + 2;

    typedef struct {
        logic [26:0]   mant;
        logic [EW-1:0] ex;
        logic [4:0]    shift;
        logic          zero;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mant_normalize_if #(.W(W)) bus ();

    mant_normalize #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t model(input logic [26:0] m, input logic [EW-1:0] e);
        exp_t r;
        r.mant  = m;
        r.ex    = e;
        r.shift = '0;
        r.zero  = (m == 27'd0);
        if (m != 27'd0) begin
            while (!r.mant[26] && r.ex != '0) begin
                r.mant  = r.mant << 1;
                r.ex    = r.ex - 1'b1;
                r.shift = r.shift + 1'b1;
            end
        end
        return r;
    endfunction

    // Offer one word; returns just after the negedge following the accept edge.
    task automatic drive_accept(input logic [26:0] m, input logic [EW-1:0] e, input bit keep);
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_mant  = m;
        bus.in_exp   = e;
        sb.push_back(model(m, e));
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    // Wait for the result, compare with the scoreboard head, stall `hold`
    // cycles, then complete the output handshake.
    task automatic collect(input int hold, input string name);
        int   cyc = 0;
        exp_t x;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.out_valid === 1'b1) break;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL %s_timeout out_valid=%b queued=%0d required out_valid=1", name, bus.out_valid, sb.size());
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        x = sb.pop_front();
        checks++;
        if (bus.out_mant !== x.mant || bus.out_exp !== x.ex) begin
            failures++;
            $display("FAIL %s_data mant=%h exp=%0d required mant=%h exp=%0d", name, bus.out_mant, bus.out_exp, x.mant, x.ex);
        end
        checks++;
        if (bus.out_shift !== x.shift || bus.out_zero !== x.zero) begin
            failures++;
            $display("FAIL %s_flags shift=%0d zero=%b required shift=%0d zero=%b", name, bus.out_shift, bus.out_zero, x.shift, x.zero);
        end
        checks++;
        if (cyc != 2 + int'(x.shift)) begin
            failures++;
            $display("FAIL %s_latency got=%0d required=%0d", name, cyc, 2 + int'(x.shift));
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_mant !== x.mant ||
                bus.out_exp !== x.ex || bus.out_shift !== x.shift || bus.out_zero !== x.zero) begin
                failures++;
                $display("FAIL %s_hold cycle=%0d valid=%b ready=%b mant=%h exp=%0d shift=%0d required valid=1 ready=0 mant=%h exp=%0d shift=%0d",
                         name, i, bus.out_valid, bus.in_ready, bus.out_mant, bus.out_exp, bus.out_shift, x.mant, x.ex, x.shift);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_release out_valid=%b in_ready=%b required 0 1", name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_mant !== 27'd0 ||
            bus.out_exp !== '0 || bus.out_shift !== 5'd0 || bus.out_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_state ready=%b valid=%b mant=%h exp=%0d shift=%0d zero=%b required 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_mant, bus.out_exp, bus.out_shift, bus.out_zero);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_normal_shift();
        drive_accept(27'h0400000, 10'd130, 1'b0);
        collect(0, "shift4");
        drive_accept(27'h0100000, 10'd130, 1'b0);
        collect(0, "shift6");
    endtask

    task automatic test_normalized_and_max();
        drive_accept(27'h4000001, 10'd77, 1'b0);
        collect(0, "already_norm");
        drive_accept(27'h0000001, 10'd200, 1'b0);
        collect(0, "max_shift");
    endtask

    task automatic test_zero_and_floor();
        drive_accept(27'h0000000, 10'd55, 1'b0);
        collect(0, "zero");
        drive_accept(27'h0000100, 10'd3, 1'b0);
        collect(0, "exp_floor");
        drive_accept(27'h0000010, 10'd0, 1'b0);
        collect(0, "exp_zero_in");
    endtask

    task automatic test_backpressure();
        drive_accept(27'h0002000, 10'd40, 1'b0);
        // A second word is offered while the first is in flight and stalled.
        bus.in_valid = 1'b1;
        bus.in_mant  = 27'h0000300;
        bus.in_exp   = 10'd90;
        collect(10, "backpressure");
        // Handshake edge has passed; the second word must not have been taken.
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_not_taken in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        sb.push_back(model(27'h0000300, 10'd90));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        collect(0, "bp_second");
    endtask

    task automatic test_reset_mid();
        drive_accept(27'h0000001, 10'd200, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_mant !== 27'd0 ||
            bus.out_exp !== '0 || bus.out_shift !== 5'd0 || bus.out_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid ready=%b valid=%b mant=%h exp=%0d shift=%0d zero=%b required 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_mant, bus.out_exp, bus.out_shift, bus.out_zero);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        drive_accept(27'h0400000, 10'd130, 1'b0);
        collect(0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [26:0]   m;
        logic [EW-1:0] e;
        // out_ready held high outside DONE must not disturb anything.
        for (int k = 0; k < 6; k++) begin
            m = 27'($urandom >> $urandom_range(5, 31));
            e = 10'($urandom_range(0, 1023));
            bus.out_ready = 1'b1;
            drive_accept(m, e, 1'b0);
            collect(0, "b2b");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_shift();
        test_normalized_and_max();
        test_zero_and_floor();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
